// File: rtl/boot_loader_ctrl.sv
// boot_loader_ctrl
//   Boot sequencer between a byte-stream source (UART RX) and the code RAM
//   write port. It holds the core in reset while receiving a length-prefixed,
//   checksummed image, writes the image into code RAM, then releases the core.
//
//   Image: LEN_LO, LEN_HI (N words), 4*N payload bytes (little-endian per word),
//          CSUM = mod-256 sum of payload bytes.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   boot_skip           1 in IDLE = skip loading and run preloaded RAM
//   byte_valid/data     RX byte stream; byte_ready accepts it
//   mem_req/we/addr/wdata, mem_gnt   code RAM write port (held until gnt)
//   core_rst_n          core reset, active low
//   boot_sequence_done  image loaded and core released
//   boot_error          sticky error (bad length, bad checksum, timeout)
module boot_loader_ctrl #(
    parameter int ADDR_W         = 12,
    parameter int MEM_WORDS      = 4096,
    parameter int BASE_ADDR      = 0,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              boot_skip,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    output logic              core_rst_n,
    output logic              boot_sequence_done,
    output logic              boot_error
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN0, S_LEN1, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERROR
    } state_t;

    localparam int              TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [16:0]     MAX_N    = 17'(MEM_WORDS - BASE_ADDR);

    state_t        state, next_state;
    logic [7:0]    len_lo;
    logic [15:0]   n_words;
    logic [15:0]   word_cnt;
    logic [1:0]    byte_cnt;
    logic [7:0]    sum;
    logic [31:0]   word;
    logic [TW-1:0] tmo_cnt;

    logic          accept;
    logic [15:0]   n_new;
    logic [15:0]   word_cnt_inc;
    logic          timing;
    logic          tmo_hit;

    assign accept       = byte_valid & byte_ready;
    assign n_new        = {byte_data, len_lo};
    assign word_cnt_inc = word_cnt + 16'd1;
    assign timing       = (state == S_LEN1) || (state == S_DATA) ||
                          (state == S_WRITE) || (state == S_CSUM);
    // Fires on the TIMEOUT_CYCLES-th consecutive idle cycle.
    assign tmo_hit      = timing && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    // A byte or grant in the same cycle as the timeout takes priority.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (boot_skip) next_state = S_DONE;
                     else if (accept) next_state = S_LEN1;
            S_LEN0:  next_state = S_LEN1;
            S_LEN1:  if (accept) begin
                         if (n_new == 16'd0 || {1'b0, n_new} > MAX_N) next_state = S_ERROR;
                         else                                          next_state = S_DATA;
                     end else if (tmo_hit) next_state = S_ERROR;
            S_DATA:  if (accept) begin
                         if (byte_cnt == 2'd3) next_state = S_WRITE;
                     end else if (tmo_hit) next_state = S_ERROR;
            S_WRITE: if (mem_gnt) next_state = (word_cnt_inc == n_words) ? S_CSUM : S_DATA;
                     else if (tmo_hit) next_state = S_ERROR;
            S_CSUM:  if (accept) next_state = (byte_data == sum) ? S_DONE : S_ERROR;
                     else if (tmo_hit) next_state = S_ERROR;
            default: next_state = state;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_lo             <= '0;
            n_words            <= '0;
            word_cnt           <= '0;
            byte_cnt           <= '0;
            sum                <= '0;
            word               <= '0;
            tmo_cnt            <= '0;
            byte_ready         <= 1'b0;
            mem_req            <= 1'b0;
            mem_we             <= 1'b0;
            mem_addr           <= ADDR_W'(BASE_ADDR);
            mem_wdata          <= '0;
            core_rst_n         <= 1'b0;
            boot_sequence_done <= 1'b0;
            boot_error         <= 1'b0;
        end else begin
            if (accept || !timing)        tmo_cnt <= '0;
            else if (tmo_cnt != TMO_LAST) tmo_cnt <= tmo_cnt + TW'(1);

            case (state)
                S_IDLE: if (accept && !boot_skip) len_lo <= byte_data;
                S_LEN1: if (accept) begin
                    n_words  <= n_new;
                    byte_cnt <= '0;
                    word_cnt <= '0;
                    sum      <= '0;
                end
                S_DATA: if (accept) begin
                    word     <= {byte_data, word[31:8]};
                    sum      <= sum + byte_data;
                    byte_cnt <= byte_cnt + 2'd1;
                end
                S_WRITE: if (mem_gnt) word_cnt <= word_cnt_inc;
                default: ;
            endcase

            // Handshake-facing outputs follow next_state so they match the
            // state the FSM is in during the following cycle.
            byte_ready <= (next_state == S_IDLE && !boot_skip) || next_state == S_LEN1 ||
                          next_state == S_DATA || next_state == S_CSUM;
            mem_req    <= (next_state == S_WRITE);
            mem_we     <= (next_state == S_WRITE);
            if (state == S_DATA && next_state == S_WRITE) begin
                mem_addr  <= ADDR_W'(32'(BASE_ADDR) + 32'(word_cnt));
                mem_wdata <= {byte_data, word[31:8]};
            end
            boot_error <= (next_state == S_ERROR);

            // Core release lags DONE entry by one cycle.
            core_rst_n         <= (state == S_DONE);
            boot_sequence_done <= (state == S_DONE);
        end
    end

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// tb_boot_loader_ctrl
//   Self-checking bench for boot_loader_ctrl. Images are generated with
//   $urandom and checked against a behavioural image parser that predicts the
//   RAM writes and the final done/error outcome.
module tb_boot_loader_ctrl;

    localparam int ADDR_W = 12;
    localparam int MEMW   = 4096;
    localparam int TMO    = 100;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              boot_skip = 1'b0;
    logic              byte_valid = 1'b0;
    logic [7:0]        byte_data = 8'h00;
    logic              byte_ready;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_gnt = 1'b0;
    logic              core_rst_n;
    logic              boot_sequence_done;
    logic              boot_error;

    boot_loader_ctrl #(.ADDR_W(ADDR_W), .MEM_WORDS(MEMW), .BASE_ADDR(0), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .boot_skip(boot_skip),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .core_rst_n(core_rst_n),
        .boot_sequence_done(boot_sequence_done), .boot_error(boot_error)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int gnt_mode = 0;          // 0 random, 1 held low, 2 always high
    int hs_cnt = 0;
    int req_cnt = 0;
    logic [ADDR_W-1:0] got_addr[$];
    logic [31:0]       got_data[$];
    logic [ADDR_W-1:0] exp_addr[$];
    logic [31:0]       exp_data[$];
    int exp_consumed;
    bit exp_done, exp_err;

    always @(negedge clk) begin
        if (gnt_mode == 0)      mem_gnt = 1'($urandom_range(0, 1));
        else if (gnt_mode == 1) mem_gnt = 1'b0;
        else                    mem_gnt = 1'b1;
    end

    // Values here are stable across the edge (driven at negedge or registered).
    always @(posedge clk) begin
        if (byte_valid && byte_ready) hs_cnt++;
        if (mem_req) req_cnt++;
        if (mem_req && mem_we && mem_gnt) begin
            got_addr.push_back(mem_addr);
            got_data.push_back(mem_wdata);
        end
    end

    // Behavioural image parser.
    task automatic model(input logic [7:0] img[$]);
        int n;
        logic [7:0] s;
        exp_addr.delete();
        exp_data.delete();
        n = int'(img[0]) + 256 * int'(img[1]);
        if (n == 0 || n > MEMW) begin
            exp_consumed = 2; exp_done = 0; exp_err = 1;
            return;
        end
        s = 8'h00;
        for (int w = 0; w < n; w++) begin
            exp_addr.push_back(ADDR_W'(w));
            exp_data.push_back({img[5+4*w], img[4+4*w], img[3+4*w], img[2+4*w]});
            for (int b = 0; b < 4; b++) s = s + img[2+4*w+b];
        end
        exp_consumed = 3 + 4 * n;
        exp_done = (img[2+4*n] == s);
        exp_err  = !exp_done;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0; byte_valid = 1'b0; boot_skip = 1'b0;
        #12;
        got_addr.delete(); got_data.delete();
        hs_cnt = 0; req_cnt = 0;
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok = 0;
        @(negedge clk); byte_valid = 1'b1; byte_data = b;
        for (int i = 0; i < 300; i++) begin
            if (byte_ready) begin @(posedge clk); #1; ok = 1; break; end
            @(negedge clk);
        end
        byte_valid = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL byte_accept: byte %h not accepted within 300 cycles", b); end
    endtask

    task automatic run_image(input logic [7:0] img[$]);
        reset_dut();
        model(img);
        for (int i = 0; i < exp_consumed; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send_byte(img[i]);
        end
    endtask

    task automatic wait_end();
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (boot_sequence_done || boot_error) break;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if ({byte_ready, mem_req, mem_we, mem_addr, mem_wdata, core_rst_n, boot_sequence_done, boot_error} !== '0) begin
            errors++; $display("FAIL reset_values: got rdy=%b req=%b we=%b addr=%h wd=%h crst=%b done=%b err=%b required all 0",
                byte_ready, mem_req, mem_we, mem_addr, mem_wdata, core_rst_n, boot_sequence_done, boot_error);
        end
    endtask

    task automatic test_golden();
        logic [7:0] img[$];
        img = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h82};
        gnt_mode = 0;
        run_image(img);
        @(negedge clk);
        checks++;
        if (boot_sequence_done !== 1'b0) begin errors++; $display("FAIL golden_latency_early: done=%b required 0", boot_sequence_done); end
        @(negedge clk);
        checks++;
        if ({boot_sequence_done, core_rst_n, boot_error, byte_ready} !== 4'b1100) begin
            errors++; $display("FAIL golden_done: done=%b crst=%b err=%b rdy=%b required 1 1 0 0",
                boot_sequence_done, core_rst_n, boot_error, byte_ready);
        end
        checks++;
        if (got_addr.size() != 2) begin
            errors++; $display("FAIL golden_wcount: got %0d writes required 2", got_addr.size());
        end else begin
            checks++;
            if (got_addr[0] !== 12'h000 || got_data[0] !== 32'h0000_0013 ||
                got_addr[1] !== 12'h001 || got_data[1] !== 32'h0000_006F) begin
                errors++; $display("FAIL golden_writes: got %h@%h %h@%h required 00000013@000 0000006f@001",
                    got_data[0], got_addr[0], got_data[1], got_addr[1]);
            end
        end
    endtask

    task automatic test_bad_csum();
        logic [7:0] img[$];
        img = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h83};
        gnt_mode = 0;
        run_image(img);
        wait_end();
        checks++;
        if ({boot_error, boot_sequence_done, core_rst_n} !== 3'b100) begin
            errors++; $display("FAIL bad_csum_flags: err=%b done=%b crst=%b required 1 0 0",
                boot_error, boot_sequence_done, core_rst_n);
        end
        checks++;
        if (got_addr.size() != 2) begin errors++; $display("FAIL bad_csum_wcount: got %0d required 2", got_addr.size()); end
    endtask

    task automatic test_bad_len();
        logic [15:0] lens[2];
        logic [7:0] img[$];
        lens[0] = 16'h0000; lens[1] = 16'h1001;
        gnt_mode = 2;
        for (int k = 0; k < 2; k++) begin
            img = '{lens[k][7:0], lens[k][15:8], 8'h11, 8'h22, 8'h33, 8'h44, 8'h0A};
            run_image(img);
            wait_end();
            repeat (4) @(negedge clk);
            checks++;
            if ({boot_error, boot_sequence_done, byte_ready} !== 3'b100 || req_cnt != 0 || hs_cnt != 2) begin
                errors++; $display("FAIL bad_len_%h: err=%b done=%b rdy=%b req_cycles=%0d bytes=%0d required 1 0 0 0 2",
                    lens[k], boot_error, boot_sequence_done, byte_ready, req_cnt, hs_cnt);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] img[$];
        logic [7:0] s;
        int n;
        gnt_mode = 0;
        for (int it = 0; it < 6; it++) begin
            n = $urandom_range(1, 6);
            img.delete();
            img.push_back(8'(n)); img.push_back(8'h00);
            s = 8'h00;
            for (int i = 0; i < 4 * n; i++) begin
                img.push_back(8'($urandom_range(0, 255)));
                s = s + img[img.size()-1];
            end
            img.push_back((it % 3 == 2) ? s + 8'(1 + $urandom_range(0, 250)) : s);
            run_image(img);
            wait_end();
            checks++;
            if (boot_sequence_done !== exp_done || boot_error !== exp_err || core_rst_n !== exp_done) begin
                errors++; $display("FAIL random_%0d_outcome: done=%b err=%b crst=%b required %b %b %b",
                    it, boot_sequence_done, boot_error, core_rst_n, exp_done, exp_err, exp_done);
            end
            checks++;
            if (got_addr.size() != exp_addr.size()) begin
                errors++; $display("FAIL random_%0d_wcount: got %0d required %0d", it, got_addr.size(), exp_addr.size());
            end else begin
                for (int w = 0; w < exp_addr.size(); w++) begin
                    checks++;
                    if (got_addr[w] !== exp_addr[w] || got_data[w] !== exp_data[w]) begin
                        errors++; $display("FAIL random_%0d_write%0d: got %h@%h required %h@%h",
                            it, w, got_data[w], got_addr[w], exp_data[w], exp_addr[w]);
                    end
                end
            end
        end
    endtask

    task automatic test_gnt_stall();
        logic [7:0] img[$];
        logic [ADDR_W-1:0] a0;
        logic [31:0] d0;
        bit ok = 0;
        img = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h0E};
        reset_dut();
        model(img);
        gnt_mode = 1;
        for (int i = 0; i < 6; i++) send_byte(img[i]);
        @(negedge clk);
        a0 = mem_addr; d0 = mem_wdata;
        checks++;
        if (mem_req !== 1'b1 || a0 !== exp_addr[0] || d0 !== exp_data[0]) begin
            errors++; $display("FAIL stall_req: req=%b %h@%h required 1 %h@%h", mem_req, d0, a0, exp_data[0], exp_addr[0]);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (mem_req !== 1'b1 || byte_ready !== 1'b0 || mem_addr !== a0 || mem_wdata !== d0) begin
                errors++; $display("FAIL stall_hold_%0d: req=%b rdy=%b %h@%h required 1 0 %h@%h",
                    c, mem_req, byte_ready, mem_wdata, mem_addr, d0, a0);
            end
        end
        gnt_mode = 2;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!mem_req) begin ok = 1; break; end
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL stall_release: mem_req still %b after gnt", mem_req); end
        send_byte(img[6]);
        wait_end();
        checks++;
        if (got_addr.size() != 1 || boot_sequence_done !== 1'b1) begin
            errors++; $display("FAIL stall_once: writes=%0d done=%b required 1 1", got_addr.size(), boot_sequence_done);
        end
    endtask

    task automatic test_timeout();
        int rise = -1;
        gnt_mode = 2;
        reset_dut();
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        for (int j = 1; j <= 300; j++) begin
            @(negedge clk);
            if (boot_error) begin rise = j; break; end
        end
        checks++;
        if (rise < 100 || rise > 102) begin
            errors++; $display("FAIL timeout_cycles: error after %0d idle cycles required 100..102", rise);
        end
        checks++;
        if (core_rst_n !== 1'b0 || byte_ready !== 1'b0 || req_cnt != 0) begin
            errors++; $display("FAIL timeout_state: crst=%b rdy=%b req_cycles=%0d required 0 0 0", core_rst_n, byte_ready, req_cnt);
        end
    endtask

    task automatic test_skip();
        rst_n = 1'b0; boot_skip = 1'b1; byte_valid = 1'b1; byte_data = 8'h55;
        #12;
        hs_cnt = 0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); @(negedge clk);
        checks++;
        if ({boot_sequence_done, core_rst_n, byte_ready, boot_error} !== 4'b1100 || hs_cnt != 0) begin
            errors++; $display("FAIL skip: done=%b crst=%b rdy=%b err=%b bytes=%0d required 1 1 0 0 0",
                boot_sequence_done, core_rst_n, byte_ready, boot_error, hs_cnt);
        end
        byte_valid = 1'b0; boot_skip = 1'b0;
    endtask

    task automatic test_reset_mid();
        gnt_mode = 2;
        reset_dut();
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h01); send_byte(8'h02);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({byte_ready, mem_req, mem_we, mem_addr, mem_wdata, core_rst_n, boot_sequence_done, boot_error} !== '0) begin
            errors++; $display("FAIL reset_mid: rdy=%b req=%b addr=%h wd=%h crst=%b done=%b err=%b required all 0",
                byte_ready, mem_req, mem_addr, mem_wdata, core_rst_n, boot_sequence_done, boot_error);
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (byte_ready !== 1'b1) begin errors++; $display("FAIL reset_mid_idle: rdy=%b required 1", byte_ready); end
    endtask

    initial begin
        test_reset();
        test_golden();
        test_bad_csum();
        test_bad_len();
        test_random();
        test_gnt_stall();
        test_timeout();
        test_skip();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
